// File: rtl/ps2_mouse_ctrl.sv
// rtl/ps2_mouse_ctrl.sv - PS/2 mouse init sequencer and stream packet assembler
//
// Purpose:
//   Drives the mouse init handshake on the aux byte channel (FF reset, FA ack,
//   AA BAT, 00 ID, F4 enable, FA ack). It retries the whole sequence on a bad
//   byte, a transmit error or a timeout, and it latches an error once the
//   retries are used up. In stream mode it assembles movement packets into a
//   one-entry record buffer for the register block.
//   Optional wheel support: define PS2_MOUSE_WHEEL_EN. The init sequence then
//   adds the F3 C8 / F3 64 / F3 50 knock, F2 and an ID read. ID 03 selects
//   4-byte packets.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   restart              pulse: abandon everything, restart init from FF
//   tx_aux_*             command byte out, write held until ack/error pulse
//   rx_aux_*             received byte in, rx_aux_read consumes it
//   init_done/init_error stream enabled / retries exhausted (sticky)
//   pkt_valid/pkt_ready  packet record handshake
//   pkt_buttons/dx/dy/ovf/dz  packet record fields
//   pkt_dropped          pulse: completed packet lost, buffer was full
module ps2_mouse_ctrl #(
    parameter int TIMEOUT_CYCLES = 26000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    output logic [7:0] tx_aux_data,
    output logic       tx_aux_write,
    input  logic       tx_aux_write_ack,
    input  logic       tx_error_no_aux_ack,
    input  logic [7:0] rx_aux_data,
    input  logic       rx_aux_data_ready,
    output logic       rx_aux_read,
    output logic       init_done,
    output logic       init_error,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic [2:0] pkt_buttons,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic [1:0] pkt_ovf,
    output logic [3:0] pkt_dz,
    output logic       pkt_dropped
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);

    typedef enum logic [3:0] {
        S_RST_TX,
        S_W_ACK,
        S_W_BAT,
        S_W_ID,
        S_SR_TX,
        S_SR_ACK,
        S_ID_TX,
        S_ID_ACK,
        S_W_ID2,
        S_EN_TX,
        S_W_EN_ACK,
        S_STREAM,
        S_FAIL,
        S_ERROR
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   retries_q;
    logic [TW-1:0]   timer_q;
    logic [1:0]      idx_q;
    logic            rd_q;
    logic [7:0]      rx_byte_q;
    logic [7:0]      tx_data_q;
    logic            tx_write_q;
    logic            init_done_q;
    logic            init_error_q;
    logic            pkt_valid_q;
    logic [2:0]      buttons_q;
    logic [8:0]      dx_q;
    logic [8:0]      dy_q;
    logic [1:0]      ovf_q;
    logic            dropped_q;
    // Packet header without the always-one sync bit: {ovf[1:0], sy, sx, buttons[2:0]}
    logic [6:0]      hdr_q;
    logic [7:0]      b1_q;

    // Per-state command byte (transmit states) or expected byte (wait states)
    logic [7:0]      st_byte;
    state_t          st_next;
    logic            byte_ok;
    logic            timed_out;
    logic            pkt_done;
    logic [7:0]      pkt_b2;

`ifdef PS2_MOUSE_WHEEL_EN
    logic [2:0]      sr_idx_q;
    logic            wheel_q;
    logic [7:0]      b2_q;
    logic [3:0]      dz_q;
    logic [7:0]      sr_cmd;

    // Sample-rate knock: F3 C8 F3 64 F3 50
    always_comb begin
        sr_cmd = 8'hF3;
        case (sr_idx_q)
            3'd1:    sr_cmd = 8'hC8;
            3'd3:    sr_cmd = 8'h64;
            3'd5:    sr_cmd = 8'h50;
            default: sr_cmd = 8'hF3;
        endcase
    end
`endif

    always_comb begin
        st_byte = 8'hFA;
        st_next = S_ERROR;
        case (state_q)
            S_RST_TX:   begin st_byte = 8'hFF; st_next = S_W_ACK;    end
            S_W_ACK:    begin st_byte = 8'hFA; st_next = S_W_BAT;    end
            S_W_BAT:    begin st_byte = 8'hAA; st_next = S_W_ID;     end
`ifdef PS2_MOUSE_WHEEL_EN
            S_W_ID:     begin st_byte = 8'h00; st_next = S_SR_TX;    end
            S_SR_TX:    begin st_byte = sr_cmd; st_next = S_SR_ACK;  end
            S_SR_ACK:   begin
                st_byte = 8'hFA;
                st_next = (sr_idx_q == 3'd5) ? S_ID_TX : S_SR_TX;
            end
            S_ID_TX:    begin st_byte = 8'hF2; st_next = S_ID_ACK;   end
            S_ID_ACK:   begin st_byte = 8'hFA; st_next = S_W_ID2;    end
            S_W_ID2:    begin st_byte = 8'h00; st_next = S_EN_TX;    end
`else
            S_W_ID:     begin st_byte = 8'h00; st_next = S_EN_TX;    end
`endif
            S_EN_TX:    begin st_byte = 8'hF4; st_next = S_W_EN_ACK; end
            S_W_EN_ACK: begin st_byte = 8'hFA; st_next = S_STREAM;   end
            default:    begin st_byte = 8'hFA; st_next = S_ERROR;    end
        endcase
    end

    always_comb begin
        timed_out = (timer_q == TMAX);
`ifdef PS2_MOUSE_WHEEL_EN
        // The ID read after the knock accepts 03 (wheel) as well as 00
        byte_ok  = (rx_byte_q == st_byte) ||
                   ((state_q == S_W_ID2) && (rx_byte_q == 8'h03));
        pkt_done = (state_q == S_STREAM) && rd_q &&
                   (((idx_q == 2'd2) && !wheel_q) || (idx_q == 2'd3));
        pkt_b2   = wheel_q ? b2_q : rx_byte_q;
`else
        byte_ok  = (rx_byte_q == st_byte);
        pkt_done = (state_q == S_STREAM) && rd_q && (idx_q == 2'd2);
        pkt_b2   = rx_byte_q;
`endif
    end

    // The byte is captured when rx_aux_data_ready is sampled and is acted on in
    // the following cycle, the one in which rx_aux_read is high. That cycle
    // (rd_q) is the byte event for the state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RST_TX;
            retries_q    <= '0;
            timer_q      <= '0;
            idx_q        <= 2'd0;
            rd_q         <= 1'b0;
            rx_byte_q    <= 8'h00;
            tx_data_q    <= 8'h00;
            tx_write_q   <= 1'b0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            pkt_valid_q  <= 1'b0;
            buttons_q    <= 3'd0;
            dx_q         <= 9'd0;
            dy_q         <= 9'd0;
            ovf_q        <= 2'd0;
            dropped_q    <= 1'b0;
            hdr_q        <= 7'd0;
            b1_q         <= 8'h00;
`ifdef PS2_MOUSE_WHEEL_EN
            sr_idx_q     <= 3'd0;
            wheel_q      <= 1'b0;
            b2_q         <= 8'h00;
            dz_q         <= 4'd0;
`endif
        end else begin
            // Byte consumption runs in every state. rd_q is never high twice in a row.
            rd_q <= rx_aux_data_ready & ~rd_q;
            if (rx_aux_data_ready & ~rd_q) begin
                rx_byte_q <= rx_aux_data;
            end

            // One-entry output buffer. A completion in the handshake cycle reloads it.
            dropped_q <= 1'b0;
            if (pkt_valid_q && pkt_ready) begin
                pkt_valid_q <= 1'b0;
            end
            if (pkt_done) begin
                if (!pkt_valid_q || pkt_ready) begin
                    pkt_valid_q <= 1'b1;
                    buttons_q   <= hdr_q[2:0];
                    dx_q        <= {hdr_q[3], b1_q};
                    dy_q        <= {hdr_q[4], pkt_b2};
                    ovf_q       <= hdr_q[6:5];
`ifdef PS2_MOUSE_WHEEL_EN
                    dz_q        <= wheel_q ? rx_byte_q[3:0] : 4'd0;
`endif
                end else begin
                    dropped_q <= 1'b1;
                end
            end

            if (restart) begin
                state_q      <= S_RST_TX;
                retries_q    <= '0;
                timer_q      <= '0;
                idx_q        <= 2'd0;
                tx_write_q   <= 1'b0;
                init_done_q  <= 1'b0;
                init_error_q <= 1'b0;
                pkt_valid_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_RST_TX, S_EN_TX, S_SR_TX, S_ID_TX: begin
                        timer_q   <= '0;
                        tx_data_q <= st_byte;
                        if (tx_aux_write_ack) begin
                            tx_write_q <= 1'b0;
                            state_q    <= st_next;
                        end else if (tx_error_no_aux_ack) begin
                            tx_write_q <= 1'b0;
                            state_q    <= S_FAIL;
                        end else begin
                            tx_write_q <= 1'b1;
                        end
                    end

                    S_W_ACK, S_W_BAT, S_W_ID, S_SR_ACK, S_ID_ACK, S_W_ID2, S_W_EN_ACK: begin
                        if (rd_q) begin
                            timer_q <= '0;
                            if (byte_ok) begin
                                state_q <= st_next;
                                if (state_q == S_W_EN_ACK) begin
                                    init_done_q <= 1'b1;
                                    idx_q       <= 2'd0;
                                end
`ifdef PS2_MOUSE_WHEEL_EN
                                if (state_q == S_W_ID) begin
                                    sr_idx_q <= 3'd0;
                                end
                                if (state_q == S_SR_ACK) begin
                                    sr_idx_q <= sr_idx_q + 3'd1;
                                end
                                if (state_q == S_W_ID2) begin
                                    wheel_q <= (rx_byte_q == 8'h03);
                                end
`endif
                            end else begin
                                state_q <= S_FAIL;
                            end
                        end else if (timed_out) begin
                            state_q <= S_FAIL;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end

                    S_FAIL: begin
                        timer_q <= '0;
                        if (retries_q < RMAX) begin
                            retries_q <= retries_q + RW'(1);
                            state_q   <= S_RST_TX;
                        end else begin
                            init_error_q <= 1'b1;
                            state_q      <= S_ERROR;
                        end
                    end

                    S_STREAM: begin
                        if (rd_q) begin
                            timer_q <= '0;
                            case (idx_q)
                                2'd0: begin
                                    // Bit 3 of the first byte is always set; otherwise resync
                                    if (rx_byte_q[3]) begin
                                        hdr_q <= {rx_byte_q[7:4], rx_byte_q[2:0]};
                                        idx_q <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    b1_q  <= rx_byte_q;
                                    idx_q <= 2'd2;
                                end
                                2'd2: begin
`ifdef PS2_MOUSE_WHEEL_EN
                                    if (wheel_q) begin
                                        b2_q  <= rx_byte_q;
                                        idx_q <= 2'd3;
                                    end else begin
                                        idx_q <= 2'd0;
                                    end
`else
                                    idx_q <= 2'd0;
`endif
                                end
                                default: idx_q <= 2'd0;
                            endcase
                        end else if (idx_q != 2'd0) begin
                            // Stalled partial packet: drop it and wait for a new header
                            if (timed_out) begin
                                idx_q   <= 2'd0;
                                timer_q <= '0;
                            end else begin
                                timer_q <= timer_q + TW'(1);
                            end
                        end
                    end

                    S_ERROR: begin
                        timer_q <= '0;
                    end

                    default: state_q <= S_ERROR;
                endcase
            end
        end
    end

    assign tx_aux_data  = tx_data_q;
    assign tx_aux_write = tx_write_q;
    assign rx_aux_read  = rd_q;
    assign init_done    = init_done_q;
    assign init_error   = init_error_q;
    assign pkt_valid    = pkt_valid_q;
    assign pkt_buttons  = buttons_q;
    assign pkt_dx       = dx_q;
    assign pkt_dy       = dy_q;
    assign pkt_ovf      = ovf_q;
    assign pkt_dropped  = dropped_q;
`ifdef PS2_MOUSE_WHEEL_EN
    assign pkt_dz       = dz_q;
`else
    assign pkt_dz       = 4'd0;
`endif

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb/tb_ps2_mouse_ctrl.sv - directed and randomized bench for ps2_mouse_ctrl
module tb_ps2_mouse_ctrl;

    localparam int TO = 60;
    localparam int MR = 3;
`ifdef PS2_MOUSE_WHEEL_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       restart;
    logic [7:0] tx_aux_data;
    logic       tx_aux_write;
    logic       tx_aux_write_ack;
    logic       tx_error_no_aux_ack;
    logic [7:0] rx_aux_data;
    logic       rx_aux_data_ready;
    logic       rx_aux_read;
    logic       init_done;
    logic       init_error;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [2:0] pkt_buttons;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic [1:0] pkt_ovf;
    logic [3:0] pkt_dz;
    logic       pkt_dropped;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_mouse_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .restart             (restart),
        .tx_aux_data         (tx_aux_data),
        .tx_aux_write        (tx_aux_write),
        .tx_aux_write_ack    (tx_aux_write_ack),
        .tx_error_no_aux_ack (tx_error_no_aux_ack),
        .rx_aux_data         (rx_aux_data),
        .rx_aux_data_ready   (rx_aux_data_ready),
        .rx_aux_read         (rx_aux_read),
        .init_done           (init_done),
        .init_error          (init_error),
        .pkt_valid           (pkt_valid),
        .pkt_ready           (pkt_ready),
        .pkt_buttons         (pkt_buttons),
        .pkt_dx              (pkt_dx),
        .pkt_dy              (pkt_dy),
        .pkt_ovf             (pkt_ovf),
        .pkt_dz              (pkt_dz),
        .pkt_dropped         (pkt_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed movement from the packet's sign bit and data byte
    function automatic logic [8:0] mv(input logic sgn, input logic [7:0] mag);
        int v;
        v = int'(mag) - (sgn ? 256 : 0);
        return v[8:0];
    endfunction

    task automatic check_pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        check({tag, "_btn"}, pkt_buttons, int'(b0) % 8);
        check({tag, "_dx"},  pkt_dx, mv(b0[4], b1));
        check({tag, "_dy"},  pkt_dy, mv(b0[5], b2));
        check({tag, "_ovf"}, pkt_ovf, int'(b0) / 64);
        check({tag, "_dz"},  pkt_dz, (NB == 4) ? int'(b3) % 16 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte and returns during the cycle in which rx_aux_read is high
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_aux_data       = b;
        rx_aux_data_ready = 1'b1;
        for (k = 0; k < 20; k++) begin
            tick();
            if (rx_aux_read) break;
        end
        check("rx_read", rx_aux_read, 1);
        rx_aux_data_ready = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        for (int k = 0; k < 4 * TO; k++) begin
            if (tx_aux_write) break;
            tick();
        end
        check({tag, "_wr"}, tx_aux_write, 1);
        check({tag, "_data"}, tx_aux_data, exp);
        tx_aux_write_ack = 1'b1;
        tick();
        tx_aux_write_ack = 1'b0;
        check({tag, "_wr_drop"}, tx_aux_write, 0);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        if (NB == 4) send_byte(b3);
    endtask

    task automatic consume();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        check("pkt_consumed", pkt_valid, 0);
    endtask

    task automatic do_init(input string tag);
        expect_tx({tag, "_ff"}, 8'hFF);
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'h00);
`ifdef PS2_MOUSE_WHEEL_EN
        expect_tx({tag, "_sr0"}, 8'hF3); send_byte(8'hFA);
        expect_tx({tag, "_sr1"}, 8'hC8); send_byte(8'hFA);
        expect_tx({tag, "_sr2"}, 8'hF3); send_byte(8'hFA);
        expect_tx({tag, "_sr3"}, 8'h64); send_byte(8'hFA);
        expect_tx({tag, "_sr4"}, 8'hF3); send_byte(8'hFA);
        expect_tx({tag, "_sr5"}, 8'h50); send_byte(8'hFA);
        expect_tx({tag, "_getid"}, 8'hF2); send_byte(8'hFA);
        send_byte(8'h03);
`endif
        expect_tx({tag, "_f4"}, 8'hF4);
        check({tag, "_not_done_yet"}, init_done, 0);
        send_byte(8'hFA);
        tick();
        check({tag, "_done"}, init_done, 1);
    endtask

    initial begin
        logic [7:0] r0, r1, r2, r3;
        logic [7:0] a0, a1, a2, a3;
        int saw_wr;

        rst = 1'b1; restart = 1'b0;
        tx_aux_write_ack = 1'b0; tx_error_no_aux_ack = 1'b0;
        rx_aux_data = 8'h00; rx_aux_data_ready = 1'b0; pkt_ready = 1'b0;
        repeat (3) tick();
        check("rst_tx_write", tx_aux_write, 0);
        check("rst_rx_read", rx_aux_read, 0);
        check("rst_init_done", init_done, 0);
        check("rst_init_error", init_error, 0);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_pkt_fields", {pkt_buttons, pkt_dx, pkt_dy, pkt_ovf, pkt_dz}, 0);
        check("rst_dropped", pkt_dropped, 0);
        rst = 1'b0;

        // Basic init handshake
        do_init("init1");
        check("init1_no_error", init_error, 0);

        // 09,05,FE with pkt_ready held: valid one cycle after the last read
        pkt_ready = 1'b1;
        send_pkt(8'h09, 8'h05, 8'hFE, 8'h00);
        check("lat_not_yet", pkt_valid, 0);
        tick();
        check("lat_valid", pkt_valid, 1);
        check_pkt("p09", 8'h09, 8'h05, 8'hFE, 8'h00);
        tick();
        check("lat_consumed", pkt_valid, 0);
        pkt_ready = 1'b0;

        // Resync: 00 at index 0 is thrown away
        send_byte(8'h00);
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
        tick();
        check("resync_valid", pkt_valid, 1);
        check_pkt("resync", 8'h08, 8'h01, 8'h01, 8'h00);
        consume();

        // Positive movement, wheel byte of F in wheel builds
        send_pkt(8'h08, 8'h02, 8'h03, 8'h0F);
        tick();
        check_pkt("wheel", 8'h08, 8'h02, 8'h03, 8'h0F);
        consume();

        // Randomized packets with occasional junk bytes ahead of the header
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1, 0) == 1) send_byte(8'($urandom) & 8'hF7);
            r0 = 8'($urandom) | 8'h08;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            send_pkt(r0, r1, r2, r3);
            tick();
            check("rnd_valid", pkt_valid, 1);
            check_pkt("rnd", r0, r1, r2, r3);
            consume();
        end

        // Full buffer: second packet dropped, first held
        a0 = 8'h2C; a1 = 8'h10; a2 = 8'h20; a3 = 8'h05;
        send_pkt(a0, a1, a2, a3);
        tick();
        check("bp_first_valid", pkt_valid, 1);
        send_pkt(8'h19, 8'h77, 8'h66, 8'h01);
        tick();
        check("bp_dropped_pulse", pkt_dropped, 1);
        check("bp_still_valid", pkt_valid, 1);
        check_pkt("bp_held", a0, a1, a2, a3);
        tick();
        check("bp_dropped_once", pkt_dropped, 0);

        // Completion in the handshake cycle replaces the record
        send_pkt(8'hCB, 8'h80, 8'h7F, 8'h08);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        check("hs_same_valid", pkt_valid, 1);
        check("hs_same_no_drop", pkt_dropped, 0);
        check_pkt("hs_same", 8'hCB, 8'h80, 8'h7F, 8'h08);
        consume();

        // Stalled partial packet is discarded after the timeout
        send_byte(8'h38);
        repeat (TO + 10) tick();
        r0 = 8'($urandom) | 8'h08; r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
        send_pkt(r0, r1, r2, r3);
        tick();
        check("gap_valid", pkt_valid, 1);
        check_pkt("gap", r0, r1, r2, r3);
        consume();

        // Silent device: FF is sent 1 + MR times, then error
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_clears_done", init_done, 0);
        for (int a = 0; a <= MR; a++) expect_tx("silent_ff", 8'hFF);
        saw_wr = 0;
        for (int k = 0; k < 3 * TO; k++) begin
            tick();
            if (tx_aux_write) saw_wr++;
        end
        check("silent_no_extra_ff", saw_wr, 0);
        check("silent_error", init_error, 1);
        check("silent_not_done", init_done, 0);

        // Restart from error reissues FF; an FC as BAT forces an immediate retry
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_clears_error", init_error, 0);
        expect_tx("rs_ff", 8'hFF);
        send_byte(8'hFA);
        send_byte(8'hFC);
        repeat (4) tick();
        check("bat_fc_retry", tx_aux_write, 1);
        do_init("init2");

        r0 = 8'h1D; r1 = 8'hFF; r2 = 8'h00; r3 = 8'h0A;
        send_pkt(r0, r1, r2, r3);
        tick();
        check("post_restart_valid", pkt_valid, 1);
        check_pkt("post_restart", r0, r1, r2, r3);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
